// File: rtl/dmem_banked.sv
// dmem_banked: word-banked data memory with a request/response handshake,
// programmable wait states, a registered read path and range checking.
// Optional feature macro: MISALIGN_SPLIT_EN. When defined, misaligned
// accesses are carried out as two beats over adjacent words. When undefined,
// they are rejected with rsp_err.
module dmem_banked #(
    parameter int DATA_BYTES  = 4,
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [DATA_BYTES-1:0]   req_wstrb,
    input  logic [31:0]             req_addr,
    input  logic [8*DATA_BYTES-1:0] req_wdata,
    output logic                    rsp_valid,
    output logic [8*DATA_BYTES-1:0] rsp_rdata,
    output logic                    rsp_err
);

    localparam int OFF   = $clog2(DATA_BYTES);
    localparam int WA    = ADDR_BITS - OFF;
    localparam int WORDS = 2 ** WA;
    localparam int CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACC0
`ifdef MISALIGN_SPLIT_EN
        , ACC1
`endif
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic                    we_q;
    logic                    err_q;
    logic [DATA_BYTES-1:0]   wstrb_q;
    logic [8*DATA_BYTES-1:0] wdata_q;
    logic [WA-1:0]           wordIdx_q;
    logic                    rspValid_q;
    logic [8*DATA_BYTES-1:0] rspRdata_q;
    logic                    rspErr_q;

    logic [8*DATA_BYTES-1:0] mem [WORDS];

    logic                    err_d;
    logic                    accessEdge;
    logic                    memWrite;
    logic [WA-1:0]           accIdx;
    logic [OFF-1:0]          offEff;
    logic [DATA_BYTES-1:0]   laneEn;
    logic [8*DATA_BYTES-1:0] rdBase;
    logic [8*DATA_BYTES-1:0] memWord;
    logic [DATA_BYTES-1:0]   laneWe_d;
    logic [8*DATA_BYTES-1:0] laneWdata_d;
    logic [8*DATA_BYTES-1:0] rdMerge_d;

`ifdef MISALIGN_SPLIT_EN
    logic [OFF-1:0]          off_q;
    logic [8*DATA_BYTES-1:0] rdAcc_q;

    assign offEff = off_q;
    assign accIdx = (state_q == ACC1) ? (wordIdx_q + WA'(1)) : wordIdx_q;
    assign rdBase = (state_q == ACC1) ? rdAcc_q : '0;

    // First beat owns the lanes at or above the offset, second beat the rest
    always_comb begin
        laneEn = '0;
        for (int j = 0; j < DATA_BYTES; j++) begin
            if (state_q == ACC1) begin
                laneEn[j] = (OFF'(j) < off_q);
            end else begin
                laneEn[j] = (OFF'(j) >= off_q);
            end
        end
    end
`else
    assign offEff = '0;
    assign accIdx = wordIdx_q;
    assign rdBase = '0;
    assign laneEn = '1;
`endif

    assign req_ready  = (state_q == IDLE) && !rst;
    assign accessEdge = (state_q != IDLE) && (cnt_q == '0);
    assign memWrite   = !rst && accessEdge && we_q && !err_q;
    assign memWord    = mem[accIdx];

    assign rsp_valid = rspValid_q;
    assign rsp_rdata = rspRdata_q;
    assign rsp_err   = rspErr_q;

    // Reject out-of-range, array-overflowing or unsupported misaligned requests
    always_comb begin
        err_d = |req_addr[31:ADDR_BITS];
`ifdef MISALIGN_SPLIT_EN
        if ((req_addr[OFF-1:0] != '0) && (req_addr[ADDR_BITS-1:OFF] == '1)) begin
            err_d = 1'b1;
        end
`else
        if (req_addr[OFF-1:0] != '0) begin
            err_d = 1'b1;
        end
`endif
    end

    // Rotate request lanes onto array lanes and array lanes back onto result bytes
    always_comb begin
        logic [OFF-1:0] src;
        src         = '0;
        laneWe_d    = '0;
        laneWdata_d = '0;
        rdMerge_d   = rdBase;
        for (int j = 0; j < DATA_BYTES; j++) begin
            src = OFF'(j) - offEff;
            laneWdata_d[8*j +: 8] = wdata_q[8*src +: 8];
            laneWe_d[j] = laneEn[j] && wstrb_q[src];
            if (laneEn[j]) begin
                rdMerge_d[8*src +: 8] = memWord[8*j +: 8];
            end
        end
    end

    // Byte-strobed array write on the access edge; contents survive reset
    always_ff @(posedge clk) begin
        if (memWrite) begin
            for (int j = 0; j < DATA_BYTES; j++) begin
                if (laneWe_d[j]) begin
                    mem[accIdx][8*j +: 8] <= laneWdata_d[8*j +: 8];
                end
            end
        end
    end

    // Control FSM: latch the request, count wait states, issue the response pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
            rspErr_q   <= 1'b0;
        end else begin
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
            rspErr_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        wstrb_q   <= req_wstrb;
                        wdata_q   <= req_wdata;
                        wordIdx_q <= req_addr[ADDR_BITS-1:OFF];
                        err_q     <= err_d;
`ifdef MISALIGN_SPLIT_EN
                        off_q     <= req_addr[OFF-1:0];
`endif
                        cnt_q     <= CW'(WAIT_STATES);
                        state_q   <= ACC0;
                    end
                end
                ACC0: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
`ifdef MISALIGN_SPLIT_EN
                    end else if (!err_q && (off_q != '0)) begin
                        rdAcc_q <= rdMerge_d;
                        cnt_q   <= CW'(WAIT_STATES);
                        state_q <= ACC1;
`endif
                    end else begin
                        rspValid_q <= 1'b1;
                        rspErr_q   <= err_q;
                        rspRdata_q <= (we_q || err_q) ? '0 : rdMerge_d;
                        state_q    <= IDLE;
                    end
                end
`ifdef MISALIGN_SPLIT_EN
                ACC1: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        rspValid_q <= 1'b1;
                        rspErr_q   <= 1'b0;
                        rspRdata_q <= we_q ? '0 : rdMerge_d;
                        state_q    <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_banked.sv
// tb_dmem_banked: directed and randomized checks of dmem_banked against a
// byte-addressed reference memory (DATA_BYTES=4, ADDR_BITS=10, WAIT_STATES=1).
module tb_dmem_banked;

    localparam int DB   = 4;
    localparam int AB   = 10;
    localparam int W    = 1;
    localparam int MEMB = 1 << AB;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [DB-1:0] req_wstrb;
    logic [31:0]   req_addr;
    logic [8*DB-1:0] req_wdata;
    logic          rsp_valid;
    logic [8*DB-1:0] rsp_rdata;
    logic          rsp_err;

    int compCnt;
    int failCnt;

    logic [7:0] refMem [MEMB];

    dmem_banked #(
        .DATA_BYTES (DB),
        .ADDR_BITS  (AB),
        .WAIT_STATES(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_wstrb(req_wstrb),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so a stuck design can never hang the run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no completion, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference behaviour: byte-addressed memory with the access rules applied directly
    function automatic void refAccess(input bit we, input logic [DB-1:0] strb,
                                      input logic [31:0] addr, input logic [8*DB-1:0] wdata,
                                      output logic [8*DB-1:0] rdata, output bit err,
                                      output int lat);
        int unsigned off;
        bit mis;
        off   = addr % DB;
        mis   = (off != 0);
        rdata = '0;
        err   = 1'b0;
        if (addr >= MEMB) begin
            err = 1'b1;
        end else begin
`ifdef MISALIGN_SPLIT_EN
            if (mis && (addr + DB > MEMB)) err = 1'b1;
`else
            if (mis) err = 1'b1;
`endif
        end
`ifdef MISALIGN_SPLIT_EN
        lat = (err || !mis) ? (W + 1) : 2 * (W + 1);
`else
        lat = W + 1;
`endif
        if (!err) begin
            for (int i = 0; i < DB; i++) begin
                if (we) begin
                    if (strb[i]) refMem[addr + i] = wdata[8*i +: 8];
                end else begin
                    rdata[8*i +: 8] = refMem[addr + i];
                end
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compCnt++;
        assert (observed === expected) else begin
            failCnt++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One complete request: drive, wait for accept, scramble inputs, check response
    task automatic applyStimulus(input bit we, input logic [DB-1:0] strb,
                                 input logic [31:0] addr, input logic [8*DB-1:0] wdata,
                                 output logic [8*DB-1:0] gotRdata);
        logic [8*DB-1:0] expRdata;
        bit expErr;
        int expLat;
        int lat;
        int waited;
        refAccess(we, strb, addr, wdata, expRdata, expErr, expLat);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_wstrb = strb;
        req_addr  = addr;
        req_wdata = wdata;
        waited = 0;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("req_ready_before_accept", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_wstrb = DB'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        checkOutput("latency", lat, expLat);
        checkOutput("rsp_err", rsp_err, expErr);
        checkOutput("rsp_rdata", rsp_rdata, expRdata);
        checkOutput("ready_at_response", req_ready, 1);
        gotRdata = rsp_rdata;
        @(negedge clk);
        checkOutput("rsp_valid_pulse", rsp_valid, 0);
        checkOutput("rsp_rdata_idle", rsp_rdata, 0);
        checkOutput("rsp_err_idle", rsp_err, 0);
    endtask

    initial begin
        logic [8*DB-1:0] got;
        logic [8*DB-1:0] v0;
        logic [8*DB-1:0] expA;
        logic [8*DB-1:0] expB;
        bit dummyErr;
        int dummyLat;
        bit readyBefore [8];
        bit validBefore [8];
        bit rspSeen [8];
        logic [8*DB-1:0] rdataSeen [8];
        logic [7:0] acceptVec;
        logic [7:0] rspVec;
        bit doubleRsp;
        bit sawRsp;

        compCnt   = 0;
        failCnt   = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_wstrb = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("reset_req_ready", req_ready, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 0);
        checkOutput("reset_rsp_err", rsp_err, 0);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_ready", req_ready, 1);

        // Fill the whole array so every later read has a known value
        $display("[TB] initialising array");
        for (int w = 0; w < MEMB / DB; w++) begin
            applyStimulus(1'b1, '1, 32'(w * DB), $urandom, got);
        end

        // Directed scenarios
        $display("[TB] directed scenarios");
        applyStimulus(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, got);
        applyStimulus(1'b0, 4'h0, 32'h10, 32'h0, got);
        checkOutput("read_deadbeef", got, 32'hDEADBEEF);
        applyStimulus(1'b1, 4'h2, 32'h10, 32'hAABBCCDD, got);
        applyStimulus(1'b0, 4'h0, 32'h10, 32'h0, got);
        checkOutput("read_strobed", got, 32'hDEADCCEF);
        applyStimulus(1'b1, 4'hF, 32'h14, 32'h11223344, got);
        applyStimulus(1'b0, 4'h0, 32'h12, 32'h0, got);
`ifdef MISALIGN_SPLIT_EN
        checkOutput("read_split", got, 32'h3344DEAD);
`else
        checkOutput("read_misaligned", got, 32'h0);
`endif
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, v0);
        applyStimulus(1'b1, 4'hF, 32'h400, 32'hCAFEF00D, got);
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, got);
        checkOutput("out_of_range_untouched", got, v0);
        applyStimulus(1'b0, 4'h0, 32'h3FE, 32'h0, got);
        applyStimulus(1'b1, 4'h0, 32'h30, 32'h12345678, got);
        applyStimulus(1'b1, 4'hF, 32'h0, 32'h0, got);

        // Reset while a write is in flight aborts it
        $display("[TB] reset during access");
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_wstrb = 4'hF;
        req_addr  = 32'h20;
        req_wdata = 32'h00000055;
        checkOutput("abort_ready_before", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("abort_ready_in_reset", req_ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort_ready_after_reset", req_ready, 1);
        sawRsp = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid) sawRsp = 1'b1;
        end
        checkOutput("abort_no_response", sawRsp, 0);
        applyStimulus(1'b0, 4'h0, 32'h20, 32'h0, got);

        // Back-to-back aligned reads with req_valid held high
        $display("[TB] back-to-back reads");
        refAccess(1'b0, 4'h0, 32'h40, 32'h0, expA, dummyErr, dummyLat);
        refAccess(1'b0, 4'h0, 32'h44, 32'h0, expB, dummyErr, dummyLat);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_wstrb = 4'h0;
        req_addr  = 32'h40;
        for (int k = 0; k < 8; k++) begin
            readyBefore[k] = req_ready;
            validBefore[k] = req_valid;
            @(posedge clk);
            @(negedge clk);
            if (k == 0) req_addr = 32'h44;
            if (k > 0 && readyBefore[k] && validBefore[k]) req_valid = 1'b0;
            rspSeen[k]   = rsp_valid;
            rdataSeen[k] = rsp_rdata;
        end
        acceptVec = '0;
        rspVec    = '0;
        doubleRsp = 1'b0;
        for (int k = 0; k < 8; k++) begin
            acceptVec[k] = readyBefore[k] && validBefore[k];
            rspVec[k]    = rspSeen[k];
            if (k > 0 && rspSeen[k] && rspSeen[k-1]) doubleRsp = 1'b1;
        end
        checkOutput("b2b_accept_edges", acceptVec, (8'd1 << 0) | (8'd1 << (W + 2)));
        checkOutput("b2b_rsp_edges", rspVec, (8'd1 << (W + 1)) | (8'd1 << (2 * W + 3)));
        checkOutput("b2b_first_rdata", rdataSeen[W + 1], expA);
        checkOutput("b2b_second_rdata", rdataSeen[2 * W + 3], expB);
        checkOutput("b2b_no_double_pulse", doubleRsp, 0);

        // Randomized traffic, including boundary and out-of-range addresses
        $display("[TB] randomized traffic");
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            int r;
            r = $urandom_range(0, 15);
            if (r == 0) begin
                a = $urandom | 32'h400;
            end else if (r == 1) begin
                a = 32'(MEMB - DB) + 32'($urandom_range(0, DB - 1));
            end else begin
                a = 32'($urandom_range(0, MEMB - 1));
            end
            applyStimulus(1'($urandom), DB'($urandom), a, $urandom, got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, failCnt);
        $finish;
    end

endmodule
